// File: rtl/cla_operand_stager.sv
// cla_operand_stager: registers operand pairs onto an external combinational
// carry-lookahead adder, holds them for SETTLE_CYCLES, then captures the sum.
//
// Ports:
//   i_clk, i_rst          rising-edge clock, synchronous active-high reset
//   i_valid/o_ready       upstream handshake carrying i_op1/i_op2
//   o_add1/o_add2         registered operands driving the adder inputs
//   i_sum                 adder result (WIDTH+1 bits)
//   o_valid/i_ready       downstream handshake carrying o_result/o_carry
//   o_count               completed output transactions, wraps at 16 bits
module cla_operand_stager #(
    parameter int WIDTH         = 13,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    output logic [WIDTH-1:0] o_add1,
    output logic [WIDTH-1:0] o_add2,
    input  logic [WIDTH:0]   i_sum,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_carry,
    output logic [15:0]      o_count
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] add1_q, add1_d;
    logic [WIDTH-1:0] add2_q, add2_d;
    logic [WIDTH:0]   result_q, result_d;
    logic [15:0]      count_q, count_d;
    logic             ready;
    logic             accept;

    // DONE only frees the operand registers when the result leaves
    // at the same edge, so ready there follows i_ready.
    assign ready  = ~i_rst & ((state_q == S_IDLE) |
                              ((state_q == S_DONE) & i_ready));
    assign accept = i_valid & ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        add1_d   = add1_q;
        add2_d   = add2_q;
        result_d = result_q;
        count_d  = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    add1_d  = i_op1;
                    add2_d  = i_op2;
                    cnt_d   = SETTLE_LOAD;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    result_d = i_sum;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    count_d = count_q + 16'd1;
                    if (accept) begin
                        add1_d  = i_op1;
                        add2_d  = i_op2;
                        cnt_d   = SETTLE_LOAD;
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            add1_q   <= '0;
            add2_q   <= '0;
            result_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            add1_q   <= add1_d;
            add2_q   <= add2_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

    assign o_ready  = ready;
    assign o_valid  = (state_q == S_DONE);
    assign o_add1   = add1_q;
    assign o_add2   = add2_q;
    assign o_result = result_q;
    assign o_carry  = result_q[WIDTH];
    assign o_count  = count_q;

endmodule

// File: tb/tb_cla_operand_stager.sv
// Bench for cla_operand_stager: two instances (settle 1 and 4), the bench
// plays the adder and checks transactions against plain arithmetic.
module tb_cla_operand_stager;

    logic        clk;
    logic        rst    [2];
    logic        vin    [2];
    logic        rdy    [2];
    logic [12:0] op1    [2];
    logic [12:0] op2    [2];
    logic [12:0] add1   [2];
    logic [12:0] add2   [2];
    logic [13:0] sum    [2];
    logic        ov     [2];
    logic        rin    [2];
    logic [13:0] res    [2];
    logic        carry  [2];
    logic [15:0] cnt    [2];

    int checks   = 0;
    int failures = 0;
    int cnt_exp [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        // The bench stands in for the combinational adder.
        assign sum[g] = {1'b0, add1[g]} + {1'b0, add2[g]};
        cla_operand_stager #(
            .WIDTH(13),
            .SETTLE_CYCLES((g == 0) ? 1 : 4)
        ) u_dut (
            .i_clk   (clk),
            .i_rst   (rst[g]),
            .i_valid (vin[g]),
            .o_ready (rdy[g]),
            .i_op1   (op1[g]),
            .i_op2   (op2[g]),
            .o_add1  (add1[g]),
            .o_add2  (add2[g]),
            .i_sum   (sum[g]),
            .o_valid (ov[g]),
            .i_ready (rin[g]),
            .o_result(res[g]),
            .o_carry (carry[g]),
            .o_count (cnt[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int settle(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a pair and wait (bounded) for the accept edge.
    task automatic send(input int u, input logic [12:0] a,
                        input logic [12:0] b);
        int n = 0;
        op1[u] = a;
        op2[u] = b;
        vin[u] = 1'b1;
        #1;
        while (!rdy[u] && n < 50) begin
            tick();
            n++;
        end
        chk("accept_wait", 32'(n < 50), 32'd1);
        tick();
        vin[u] = 1'b0;
        chk("add1_load", 32'(add1[u]), 32'(a));
        chk("add2_load", 32'(add2[u]), 32'(b));
    endtask

    // Wait for the result, stall it for 'hold' cycles, then take it.
    task automatic recv(input int u, input logic [12:0] a,
                        input logic [12:0] b, input int hold);
        int n = 0;
        logic [13:0] exp_sum;
        exp_sum = 14'(32'(a) + 32'(b));
        while (!ov[u] && n < 40) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(settle(u)));
        chk("result", 32'(res[u]), 32'(exp_sum));
        chk("carry", 32'(carry[u]), 32'(exp_sum[13]));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(ov[u]), 32'd1);
            chk("hold_result", 32'(res[u]), 32'(exp_sum));
            chk("hold_add1", 32'(add1[u]), 32'(a));
            chk("hold_add2", 32'(add2[u]), 32'(b));
            chk("hold_ready", 32'(rdy[u]), 32'd0);
        end
        rin[u] = 1'b1;
        #1;
        chk("done_ready", 32'(rdy[u]), 32'd1);
        tick();
        rin[u] = 1'b0;
        cnt_exp[u]++;
        chk("count", 32'(cnt[u]), 32'(cnt_exp[u] & 16'hFFFF));
        chk("valid_drop", 32'(ov[u]), 32'd0);
    endtask

    initial begin
        logic [12:0] a;
        logic [12:0] b;
        int hold;
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1;
            vin[u] = 1'b0;
            rin[u] = 1'b0;
            op1[u] = '0;
            op2[u] = '0;
            cnt_exp[u] = 0;
        end
        tick();
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_ready", 32'(rdy[u]), 32'd0);
            rst[u] = 1'b0;
        end
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_valid", 32'(ov[u]), 32'd0);
            chk("rst_count", 32'(cnt[u]), 32'd0);
            chk("rst_add1", 32'(add1[u]), 32'd0);
            chk("rst_add2", 32'(add2[u]), 32'd0);
            chk("rst_result", 32'(res[u]), 32'd0);
            chk("idle_ready", 32'(rdy[u]), 32'd1);
        end

        // Directed sums, including carry out of the top bit.
        send(0, 13'd1234, 13'd4321);
        recv(0, 13'd1234, 13'd4321, 0);
        chk("sum_5555", 32'(res[0]), 32'h15B3);
        send(0, 13'd8191, 13'd1);
        recv(0, 13'd8191, 13'd1, 0);
        chk("sum_8192", 32'(res[0]), 32'h2000);
        send(0, 13'd8191, 13'd8191);
        recv(0, 13'd8191, 13'd8191, 5);
        chk("sum_16382", 32'(res[0]), 32'h3FFE);

        // Back-to-back with no back-pressure: a result every 2 cycles.
        rin[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            a = 13'(2 * j + 1);
            b = 13'(2 * j + 2);
            op1[0] = a;
            op2[0] = b;
            vin[0] = 1'b1;
            #1;
            chk("b2b_ready", 32'(rdy[0]), 32'd1);
            tick();
            if (j == 2) vin[0] = 1'b0;
            chk("b2b_add1", 32'(add1[0]), 32'(a));
            chk("b2b_gap", 32'(ov[0]), 32'd0);
            tick();
            chk("b2b_valid", 32'(ov[0]), 32'd1);
            chk("b2b_result", 32'(res[0]), 32'(4 * j + 3));
        end
        tick();
        rin[0] = 1'b0;
        cnt_exp[0] += 3;
        chk("b2b_idle", 32'(ov[0]), 32'd0);
        chk("b2b_count", 32'(cnt[0]), 32'(cnt_exp[0]));

        // Long settle time.
        send(1, 13'd100, 13'd200);
        recv(1, 13'd100, 13'd200, 0);
        chk("sum_300", 32'(res[1]), 32'd300);

        // Reset while operands are settling discards the transaction.
        for (int u = 0; u < 2; u++) begin
            send(u, 13'd77, 13'd88);
            rst[u] = 1'b1;
            tick();
            rst[u] = 1'b0;
            cnt_exp[u] = 0;
            chk("mid_rst_valid", 32'(ov[u]), 32'd0);
            chk("mid_rst_count", 32'(cnt[u]), 32'd0);
            chk("mid_rst_add1", 32'(add1[u]), 32'd0);
            chk("mid_rst_add2", 32'(add2[u]), 32'd0);
            for (int i = 0; i < settle(u) + 1; i++) begin
                tick();
                chk("mid_rst_quiet", 32'(ov[u]), 32'd0);
            end
            send(u, 13'd10, 13'd20);
            recv(u, 13'd10, 13'd20, 0);
            chk("sum_30", 32'(res[u]), 32'd30);
        end

        // Random operands and random back-pressure on both instances.
        for (int i = 0; i < 40; i++) begin
            for (int u = 0; u < 2; u++) begin
                a = 13'($urandom);
                b = 13'($urandom);
                hold = $urandom_range(0, 3);
                send(u, a, b);
                recv(u, a, b, hold);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
